// File: rtl/main_mem_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : main_mem_ctrl
// Description : Line-oriented main memory with a fixed access latency and a
//               self-initialising store (mem[i] = i). MEM_WMASK_EN enables
//               per-word write masking through the req_wmask port.
// Revision    : 1.0 - initial release
// ============================================================================
module main_mem_ctrl #(
  parameter int ADDR_W         = 26,
  parameter int WORD_W         = 32,
  parameter int WORDS_PER_LINE = 4,
  parameter int DEPTH_WORDS    = 16384,
  parameter int LATENCY        = 4
) (
  input  logic                             clk,
  input  logic                             reset,
  input  logic                             req_valid,
  output logic                             req_ready,
  input  logic                             req_write,
  input  logic [ADDR_W-1:0]                req_addr,
  input  logic [WORD_W*WORDS_PER_LINE-1:0] req_wdata,
`ifdef MEM_WMASK_EN
  input  logic [WORDS_PER_LINE-1:0]        req_wmask,
`endif
  output logic                             resp_valid,
  input  logic                             resp_ready,
  output logic [WORD_W*WORDS_PER_LINE-1:0] resp_rdata,
  output logic                             resp_error,
  output logic                             init_done
);

  localparam int c_LINE_W = WORD_W * WORDS_PER_LINE;
  localparam int c_IDX_W  = (DEPTH_WORDS > 1) ? $clog2(DEPTH_WORDS) : 1;
  localparam int c_BASE_W = ADDR_W + $clog2(WORDS_PER_LINE);
  localparam int c_LAT_W  = (LATENCY > 1) ? $clog2(LATENCY) : 1;

  localparam logic [1:0] c_ST_INIT = 2'd0;
  localparam logic [1:0] c_ST_IDLE = 2'd1;
  localparam logic [1:0] c_ST_WAIT = 2'd2;
  localparam logic [1:0] c_ST_RESP = 2'd3;

  logic [1:0]                r_state;
  logic [1:0]                w_next_state;
  logic [c_IDX_W-1:0]        r_init_idx;
  logic                      r_init_done;
  logic [c_LAT_W-1:0]        r_lat_cnt;
  logic                      r_write;
  logic [ADDR_W-1:0]         r_addr;
  logic [c_LINE_W-1:0]       r_wdata;
  logic [WORDS_PER_LINE-1:0] w_wmask;
  logic [c_LINE_W-1:0]       r_rdata;
  logic                      r_error;
  logic [WORD_W-1:0]         r_mem [DEPTH_WORDS];

  logic [c_BASE_W-1:0]       w_base;
  logic [63:0]               w_end;
  logic [c_IDX_W-1:0]        w_base_idx;
  logic                      w_range_err;
  logic                      w_exec;
  logic                      w_init_last;
  logic [c_LINE_W-1:0]       w_rd_line;

`ifdef MEM_WMASK_EN
  logic [WORDS_PER_LINE-1:0] r_wmask;
  assign w_wmask = r_wmask;
`else
  assign w_wmask = '1;
`endif

  // Base word index kept wide enough that no line address wraps back into range.
  assign w_base      = c_BASE_W'(r_addr) * c_BASE_W'(WORDS_PER_LINE);
  assign w_end       = 64'(w_base) + 64'(WORDS_PER_LINE);
  assign w_range_err = (w_end > 64'(DEPTH_WORDS));
  assign w_base_idx  = c_IDX_W'(w_base);
  assign w_exec      = (r_state == c_ST_WAIT) && (r_lat_cnt == '0);
  assign w_init_last = (r_init_idx == c_IDX_W'(DEPTH_WORDS - 1));

  for (genvar k = 0; k < WORDS_PER_LINE; k++) begin : g_rd_line
    assign w_rd_line[k*WORD_W +: WORD_W] = r_mem[w_base_idx + c_IDX_W'(k)];
  end

  always_ff @(posedge clk) begin
    if (reset) r_state <= c_ST_INIT;
    else       r_state <= w_next_state;
  end

  always_comb begin
    w_next_state = r_state;
    case (r_state)
      c_ST_INIT: if (w_init_last) w_next_state = c_ST_IDLE;
      c_ST_IDLE: if (req_valid)   w_next_state = c_ST_WAIT;
      c_ST_WAIT: if (w_exec)      w_next_state = c_ST_RESP;
      c_ST_RESP: if (resp_ready)  w_next_state = c_ST_IDLE;
      default:                    w_next_state = c_ST_INIT;
    endcase
  end

  always_comb begin
    req_ready  = (r_state == c_ST_IDLE);
    resp_valid = (r_state == c_ST_RESP);
    resp_rdata = r_rdata;
    resp_error = r_error;
    init_done  = r_init_done;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_init_idx  <= '0;
      r_init_done <= 1'b0;
      r_lat_cnt   <= '0;
      r_write     <= 1'b0;
      r_addr      <= '0;
      r_wdata     <= '0;
`ifdef MEM_WMASK_EN
      r_wmask     <= '0;
`endif
      r_rdata     <= '0;
      r_error     <= 1'b0;
    end else begin
      case (r_state)
        c_ST_INIT: begin
          r_init_idx <= r_init_idx + 1'b1;
          if (w_init_last) r_init_done <= 1'b1;
        end
        c_ST_IDLE: begin
          if (req_valid) begin
            r_write   <= req_write;
            r_addr    <= req_addr;
            r_wdata   <= req_wdata;
`ifdef MEM_WMASK_EN
            r_wmask   <= req_wmask;
`endif
            r_lat_cnt <= c_LAT_W'(LATENCY - 1);
          end
        end
        c_ST_WAIT: begin
          if (!w_exec) begin
            r_lat_cnt <= r_lat_cnt - 1'b1;
          end else begin
            r_error <= w_range_err;
            r_rdata <= (r_write || w_range_err) ? '0 : w_rd_line;
          end
        end
        c_ST_RESP: begin
          if (resp_ready) begin
            r_error <= 1'b0;
            r_rdata <= '0;
          end
        end
        default: ;
      endcase
    end
  end

  // Storage has no reset; INIT rewrites it, and reset suppresses any pending line write.
  always_ff @(posedge clk) begin
    if (!reset) begin
      if (r_state == c_ST_INIT) begin
        r_mem[r_init_idx] <= WORD_W'(r_init_idx);
      end else if (w_exec && r_write && !w_range_err) begin
        for (int k = 0; k < WORDS_PER_LINE; k++) begin
          if (w_wmask[k]) r_mem[w_base_idx + c_IDX_W'(k)] <= r_wdata[k*WORD_W +: WORD_W];
        end
      end
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_main_mem_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : tb_main_mem_ctrl
// Description : Scoreboard bench for main_mem_ctrl against a word-array model
//               (DEPTH_WORDS=64, LATENCY=4). Honours MEM_WMASK_EN.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_main_mem_ctrl;
  localparam int ADDR_W = 26;
  localparam int WORD_W = 32;
  localparam int WPL    = 4;
  localparam int DEPTH  = 64;
  localparam int LAT    = 4;
  localparam int LW     = WORD_W * WPL;

  logic          clk = 1'b0;
  logic          reset = 1'b1;
  logic          req_valid = 1'b0;
  logic          req_ready;
  logic          req_write = 1'b0;
  logic [ADDR_W-1:0] req_addr = '0;
  logic [LW-1:0] req_wdata = '0;
`ifdef MEM_WMASK_EN
  logic [WPL-1:0] req_wmask = '1;
`endif
  logic          resp_valid;
  logic          resp_ready = 1'b0;
  logic [LW-1:0] resp_rdata;
  logic          resp_error;
  logic          init_done;

  main_mem_ctrl #(
    .ADDR_W(ADDR_W), .WORD_W(WORD_W), .WORDS_PER_LINE(WPL),
    .DEPTH_WORDS(DEPTH), .LATENCY(LAT)
  ) dut (
    .clk(clk), .reset(reset),
    .req_valid(req_valid), .req_ready(req_ready), .req_write(req_write),
    .req_addr(req_addr), .req_wdata(req_wdata),
`ifdef MEM_WMASK_EN
    .req_wmask(req_wmask),
`endif
    .resp_valid(resp_valid), .resp_ready(resp_ready), .resp_rdata(resp_rdata),
    .resp_error(resp_error), .init_done(init_done)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int failures = 0;
  logic [LW:0] exp_q[$];
  bit hold_mode = 1'b0;
  bit rr_rand = 1'b0;
  logic [WORD_W-1:0] model_mem [DEPTH];

  task automatic check(input string name, input logic [LW-1:0] act, input logic [LW-1:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: actual=%h required=%h", name, act, exp);
    end
  endtask

  task automatic timeout(input string name);
    checks++;
    failures++;
    $display("FAIL %s: timed out", name);
  endtask

  function automatic void model_init();
    for (int i = 0; i < DEPTH; i++) model_mem[i] = WORD_W'(i);
  endfunction

  // Line-level view: a line is in range iff all its words exist.
  function automatic logic [LW:0] model_access(input bit wr, input int addr,
                                               input logic [LW-1:0] wd, input logic [WPL-1:0] mask);
    longint b;
    logic [LW-1:0] rd;
    b = longint'(addr) * WPL;
    rd = '0;
    if (b + WPL > DEPTH) return {1'b1, {LW{1'b0}}};
    if (wr) begin
      for (int k = 0; k < WPL; k++)
        if (mask[k]) model_mem[int'(b) + k] = wd[k*WORD_W +: WORD_W];
      return {1'b0, {LW{1'b0}}};
    end
    for (int k = 0; k < WPL; k++) rd[k*WORD_W +: WORD_W] = model_mem[int'(b) + k];
    return {1'b0, rd};
  endfunction

  always @(posedge clk) begin
    #1;
    if (hold_mode)    resp_ready = 1'b0;
    else if (rr_rand) resp_ready = ($urandom_range(0, 3) != 0);
    else              resp_ready = 1'b1;
  end

  // Monitor: every response handshake is matched against the oldest expectation.
  always @(negedge clk) begin
    logic [LW:0] e;
    if (!reset && resp_valid && resp_ready) begin
      if (exp_q.size() == 0) begin
        checks++;
        failures++;
        $display("FAIL unexpected_resp: actual=%h required=none", resp_rdata);
      end else begin
        e = exp_q.pop_front();
        check("resp_error", LW'(resp_error), LW'(e[LW]));
        check("resp_rdata", resp_rdata, e[LW-1:0]);
      end
    end
  end

  task automatic wait_init();
    for (int i = 1; i <= DEPTH; i++) begin
      @(posedge clk);
      #1;
      if (i == DEPTH - 1) check("init_done_early", LW'(init_done), LW'(0));
      if (i == DEPTH)     check("init_done_rise", LW'(init_done), LW'(1));
    end
  endtask

  task automatic do_req(input bit wr, input int addr, input logic [LW-1:0] wd,
                        input logic [WPL-1:0] mask, input bit check_lat, input int hold);
    bit ok;
    int n;
    logic [WPL-1:0] eff;
    logic [LW-1:0] held;
`ifdef MEM_WMASK_EN
    eff = mask;
`else
    eff = '1;
`endif
    ok = 1'b0;
    for (int i = 0; i < 100; i++) begin
      @(negedge clk);
      if (req_ready) begin ok = 1'b1; break; end
    end
    if (!ok) begin timeout("req_ready_wait"); return; end
    if (hold > 0) begin hold_mode = 1'b1; resp_ready = 1'b0; end
    req_valid = 1'b1;
    req_write = wr;
    req_addr  = ADDR_W'(addr);
    req_wdata = wd;
`ifdef MEM_WMASK_EN
    req_wmask = mask;
`endif
    @(posedge clk);
    exp_q.push_back(model_access(wr, addr, wd, eff));
    #1;
    req_valid = 1'b0;
    req_write = $urandom_range(0, 1);
    req_wdata = {$urandom, $urandom, $urandom, $urandom};
    n = 0;
    for (int i = 1; i <= 50; i++) begin
      @(negedge clk);
      if (resp_valid) begin n = i; break; end
    end
    if (n == 0) begin timeout("resp_valid_wait"); return; end
    if (check_lat) check("latency", LW'(n), LW'(LAT + 1));
    if (hold > 0) begin
      held = resp_rdata;
      for (int i = 0; i < hold; i++) begin
        @(negedge clk);
        check("hold_stable", {resp_valid, req_ready, resp_rdata == held}, 3'b101);
      end
      hold_mode = 1'b0;
    end
    ok = 1'b0;
    for (int i = 0; i < 200; i++) begin
      if (resp_valid && resp_ready) begin ok = 1'b1; break; end
      @(negedge clk);
    end
    if (!ok) begin timeout("resp_handshake"); return; end
    @(negedge clk);
    check("after_handshake", {req_ready, resp_valid, resp_error}, 3'b100);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    logic [LW-1:0] dcba;
    bit ok;
    dcba = {32'hDDDD_DDDD, 32'hCCCC_CCCC, 32'hBBBB_BBBB, 32'hAAAA_AAAA};

    reset = 1'b1;
    @(negedge clk);
    check("reset_outputs", {req_ready, resp_valid, resp_error, init_done, |resp_rdata}, 5'b0);
    reset = 1'b0;
    wait_init();
    model_init();

    do_req(0, 3, '0, '1, 1, 0);
    do_req(1, 5, dcba, '1, 1, 0);
    do_req(0, 5, '0, '1, 1, 0);
    do_req(0, 4, '0, '1, 1, 0);
    do_req(0, 16, '0, '1, 1, 0);
    do_req(1, 16, dcba, '1, 1, 0);
    do_req(0, 15, '0, '1, 1, 0);
    do_req(0, 0, '0, '1, 1, 0);
`ifdef MEM_WMASK_EN
    do_req(1, 1, dcba, 4'b0101, 1, 0);
    do_req(0, 1, '0, '1, 1, 0);
    do_req(1, 7, dcba, 4'b0000, 1, 0);
    do_req(0, 7, '0, '1, 1, 0);
`endif
    do_req(0, 6, '0, '1, 1, 10);

    // Reset while a write to line 2 is still waiting out its latency.
    ok = 1'b0;
    for (int i = 0; i < 100; i++) begin
      @(negedge clk);
      if (req_ready) begin ok = 1'b1; break; end
    end
    if (!ok) timeout("req_ready_wait");
    req_valid = 1'b1;
    req_write = 1'b1;
    req_addr  = ADDR_W'(2);
    req_wdata = dcba;
    @(posedge clk);
    #1;
    req_valid = 1'b0;
    @(negedge clk);
    @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    check("midwait_reset_outputs", {req_ready, resp_valid, resp_error, init_done, |resp_rdata}, 5'b0);
    reset = 1'b0;
    wait_init();
    model_init();
    check("queue_empty_after_reset", LW'(exp_q.size()), LW'(0));
    do_req(0, 2, '0, '1, 1, 0);

    rr_rand = 1'b1;
    for (int i = 0; i < 150; i++) begin
      do_req($urandom_range(0, 1), $urandom_range(0, 17),
             {$urandom, $urandom, $urandom, $urandom}, WPL'($urandom), 1, 0);
    end
    rr_rand = 1'b0;
    repeat (5) @(negedge clk);
    check("scoreboard_drain", LW'(exp_q.size()), LW'(0));

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
`default_nettype wire
